// File: rtl/vi_pkg.sv
// Shared definitions for the issue-stage scoreboard: functional unit codes,
// pipeline latencies and bypass source select encodings.
package vi_pkg;

  typedef enum logic [1:0] {
    UNIT_ALU  = 2'd0,
    UNIT_MUL  = 2'd1,
    UNIT_LD   = 2'd2,
    UNIT_NONE = 2'd3
  } unit_e;

  typedef enum logic [2:0] {
    BYP_RF    = 3'd0,
    BYP_EXE   = 3'd1,
    BYP_MUL   = 3'd2,
    BYP_CACHE = 3'd3,
    BYP_WB    = 3'd4
  } byp_e;

  // Cycles from issue until the result appears in its producing stage.
  localparam int unsigned LAT_ALU = 1;
  localparam int unsigned LAT_LD  = 2;
  localparam int unsigned LAT_MUL = 5;

  // Stage holding the result of a unit once its counter reaches 1.
  function automatic byp_e byp_for_unit(input unit_e u);
    case (u)
      UNIT_ALU: return BYP_EXE;
      UNIT_MUL: return BYP_MUL;
      UNIT_LD:  return BYP_CACHE;
      default:  return BYP_RF;
    endcase
  endfunction

endpackage

// File: rtl/wb_slot_ring.sv
// Writeback-port reservation ring. Bit k set means the single writeback port
// is claimed by an in-flight instruction; an instruction of latency L may
// only issue if bit L is clear. The vector shifts right once per unfrozen
// cycle.
//   clk, rst      : clock, synchronous active-high reset
//   freeze        : hold the vector (core frozen on a memory miss)
//   reserve       : claim a slot this cycle
//   reserve_slot  : latency of the reserving instruction (pre-shift index)
//   check_slot    : latency of the candidate instruction
//   slot_taken    : check_slot is already claimed (index 0 never reports)
module wb_slot_ring #(
  parameter int unsigned DEPTH = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       freeze,
  input  logic       reserve,
  input  logic [2:0] reserve_slot,
  input  logic [2:0] check_slot,
  output logic       slot_taken
);

  logic [DEPTH:0] resv_q;
  logic [DEPTH:0] set_mask;
  logic [DEPTH:0] check_sh;

  always_comb begin
    set_mask = '0;
    if (reserve) begin
      set_mask = {{DEPTH{1'b0}}, 1'b1} << reserve_slot;
    end
    check_sh   = resv_q >> check_slot;
    slot_taken = check_sh[0] && (check_slot != 3'd0);
  end

  // The new reservation is merged before the shift, so it lands one below
  // its latency index after this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      resv_q <= '0;
    end else if (!freeze) begin
      resv_q <= (resv_q | set_mask) >> 1;
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue-stage hazard scheduler. Tracks the destination register of every
// in-flight ALU, multiplier and load instruction, stalls issue on RAW, WAW
// and writeback-port conflicts, and selects the bypass source per operand.
//   clk_i, rsn_i                 : clock, synchronous active-high reset
//   issue_valid_i                : decoded instruction present
//   issue_unit_i                 : 0=ALU 1=MUL 2=LD 3=no writeback
//   issue_rd_i, issue_rd_we_i    : destination register and its write enable
//   issue_rs{1,2}_i, _use_i      : source registers and read enables
//   mem_miss_i                   : load stuck in CACHE, whole core frozen
//   issue_ready_o                : instruction may issue this cycle
//   stall_core_o                 : valid instruction held back
//   byp_sel_{a,b}_o              : 0=RF 1=EXE 2=MULT5 3=CACHE 4=WB
module issue_scoreboard
  import vi_pkg::*;
#(
  parameter int unsigned NREG    = 32,
  parameter int unsigned ALU_LAT = LAT_ALU,
  parameter int unsigned LD_LAT  = LAT_LD,
  parameter int unsigned MUL_LAT = LAT_MUL
) (
  input  logic       clk_i,
  input  logic       rsn_i,
  input  logic       issue_valid_i,
  input  logic [1:0] issue_unit_i,
  input  logic [4:0] issue_rd_i,
  input  logic       issue_rd_we_i,
  input  logic [4:0] issue_rs1_i,
  input  logic [4:0] issue_rs2_i,
  input  logic       issue_rs1_use_i,
  input  logic       issue_rs2_use_i,
  input  logic       mem_miss_i,
  output logic       issue_ready_o,
  output logic       stall_core_o,
  output logic [2:0] byp_sel_a_o,
  output logic [2:0] byp_sel_b_o
);

  logic [NREG-1:0] busy_q;
  unit_e           unit_q [NREG];
  logic [2:0]      cnt_q  [NREG];

  unit_e      new_unit;
  logic [2:0] new_lat;
  logic       writes_rd;
  logic       raw_a;
  logic       raw_b;
  logic       waw;
  logic       slot_taken;
  logic       wb_conflict;
  logic       accept;

  function automatic logic [2:0] lat_of(input unit_e u);
    case (u)
      UNIT_ALU: return 3'(ALU_LAT);
      UNIT_MUL: return 3'(MUL_LAT);
      UNIT_LD:  return 3'(LD_LAT);
      default:  return 3'd0;
    endcase
  endfunction

  // Sources still more than one stage from their result would already have
  // stalled issue, so only cnt 1 (producing stage) and 0 (WB) forward.
  function automatic byp_e byp_of(input logic [4:0] s);
    if (!busy_q[s]) begin
      return BYP_RF;
    end else if (cnt_q[s] == 3'd1) begin
      return byp_for_unit(unit_q[s]);
    end else if (cnt_q[s] == 3'd0) begin
      return BYP_WB;
    end else begin
      return BYP_RF;
    end
  endfunction

  always_comb begin
    new_unit  = unit_e'(issue_unit_i);
    new_lat   = lat_of(new_unit);
    writes_rd = issue_rd_we_i && (issue_rd_i != 5'd0) && (new_unit != UNIT_NONE);
    raw_a     = issue_rs1_use_i && (issue_rs1_i != 5'd0) &&
                busy_q[issue_rs1_i] && (cnt_q[issue_rs1_i] > 3'd1);
    raw_b     = issue_rs2_use_i && (issue_rs2_i != 5'd0) &&
                busy_q[issue_rs2_i] && (cnt_q[issue_rs2_i] > 3'd1);
    waw       = writes_rd && busy_q[issue_rd_i] && (cnt_q[issue_rd_i] >= new_lat);
    wb_conflict = writes_rd && slot_taken;
  end

  assign issue_ready_o = !mem_miss_i && !raw_a && !raw_b && !waw && !wb_conflict;
  assign stall_core_o  = issue_valid_i && !issue_ready_o;
  assign accept        = issue_valid_i && issue_ready_o;
  assign byp_sel_a_o   = byp_of(issue_rs1_i);
  assign byp_sel_b_o   = byp_of(issue_rs2_i);

  wb_slot_ring #(
    .DEPTH(MUL_LAT)
  ) u_wb_slot_ring (
    .clk          (clk_i),
    .rst          (rsn_i),
    .freeze       (mem_miss_i),
    .reserve      (accept && writes_rd),
    .reserve_slot (new_lat),
    .check_slot   (new_lat),
    .slot_taken   (slot_taken)
  );

  // A new issue is written after the countdown so that re-issuing a register
  // whose entry retires on this same edge leaves it busy with the new count.
  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      busy_q <= '0;
      for (int unsigned i = 0; i < NREG; i++) begin
        cnt_q[i]  <= '0;
        unit_q[i] <= UNIT_ALU;
      end
    end else if (!mem_miss_i) begin
      for (int unsigned i = 1; i < NREG; i++) begin
        if (busy_q[i]) begin
          if (cnt_q[i] == 3'd0) begin
            busy_q[i] <= 1'b0;
          end else begin
            cnt_q[i] <= cnt_q[i] - 3'd1;
          end
        end
      end
      if (accept && writes_rd) begin
        busy_q[issue_rd_i] <= 1'b1;
        unit_q[issue_rd_i] <= new_unit;
        cnt_q[issue_rd_i]  <= new_lat;
      end
    end
  end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Issue-stage hazard scheduler for the scalar core.
- Tracks every in-flight destination register across the ALU (EXE), 5-stage multiplier (MULT1..MULT5) and load (EXE→CACHE) paths.
- Decides each cycle whether the decoded instruction may issue. Stalls on RAW hazards, WAW hazards and single-writeback-port conflicts.
- Drives the per-operand bypass source select consumed by the bypass controller and register-read mux.

Parameters:
- NREG, 32, architectural register count (x0 hardwired zero).
- ALU_LAT, 1, cycles from issue to ALU result in EXE.
- LD_LAT, 2, cycles from issue to load data in CACHE stage.
- MUL_LAT, 5, cycles from issue to product in MULT5.

Ports:
- clk_i  in  1  core clock.
- rsn_i  in  1  synchronous reset, active-high.
- issue_valid_i  in  1  decoded instruction present.
- issue_unit_i  in  2  0=ALU, 1=MUL, 2=LD, 3=no-writeback (store/branch).
- issue_rd_i  in  5  destination register.
- issue_rd_we_i  in  1  instruction writes rd.
- issue_rs1_i, issue_rs2_i  in  5 each  source registers.
- issue_rs1_use_i, issue_rs2_use_i  in  1 each  source actually read.
- mem_miss_i  in  1  CACHE stage holds a load (TLB or cache miss, tl_hit low); whole core frozen.
- issue_ready_o  out  1  instruction issues this cycle when issue_valid_i is also high.
- stall_core_o  out  1  issue_valid_i & !issue_ready_o.
- byp_sel_a_o, byp_sel_b_o  out  3 each  0=regfile, 1=EXE, 2=MULT5, 3=CACHE, 4=WB.

Behaviour:
- State per register r: busy, unit[1:0], cnt[2:0]. Also a writeback reservation vector wb_resv[MUL_LAT:0].
- Reset: all busy=0, cnt=0, wb_resv=0. Combinational outputs after reset: issue_ready_o=1, stall_core_o=0, byp_sel=0.
- Accept: acc = issue_valid_i & issue_ready_o.
- On accept with issue_rd_we_i, rd≠0 and unit≠3:
  - busy[rd]=1, unit[rd]=issue_unit_i, cnt[rd]=L(unit).
  - wb_resv[L] is set. This position is pre-shift, so the bit lands at index L-1 after that cycle's shift.
- Countdown (cycle without mem_miss_i):
  - Every busy entry with cnt>0 decrements.
  - An entry with cnt==0 is in WB this cycle; busy clears next edge.
  - wb_resv shifts right by one.
- Freeze: mem_miss_i high → no counter, busy or wb_resv change; issue_ready_o=0.
- Meaning of cnt:
  - ALU: cnt 1 = result in EXE.
  - MUL: cnt 5..1 = MULT1..MULT5.
  - LD: cnt 2 = EXE, cnt 1 = CACHE.
  - Any unit: cnt 0 = WB.
- RAW stall for source s (use bit set, s≠0): busy[s] & cnt[s]>1.
- WAW stall: issue_rd_we_i & rd≠0 & busy[rd] & cnt[rd] ≥ L(new unit).
- WB-port stall: unit≠3 & issue_rd_we_i & wb_resv[L(unit)]. wb_resv[0] is unused.
- issue_ready_o = !mem_miss_i & no RAW stall & no WAW stall & no WB-port stall.
- Bypass select per operand (valid whenever source busy):
  - cnt==1: unit ALU→1, MUL→2, LD→3.
  - cnt==0: →4.
  - Otherwise →0 (a stall is already raised when cnt>1).
- Simultaneous clear and re-issue of the same rd on one edge: new issue wins (busy=1, new cnt).
- Source equal to the rd being issued the same cycle uses old state (no self-dependence).
- x0 is never marked busy and never stalls.
- Reset asserted mid-operation: all state cleared on that edge; pending writebacks are forgotten.

Decomposition:
- Shared package vi_pkg holds:
  - unit codes (UNIT_ALU, UNIT_MUL, UNIT_LD, UNIT_NONE);
  - latency constants;
  - bypass select encodings (BYP_RF, BYP_EXE, BYP_MUL, BYP_CACHE, BYP_WB).
- One sub-module, wb_slot_ring: holds the wb_resv shift vector, the reserve/check/freeze logic and its own reset.

Test Plan:
- ALU x5 issued, next cycle ADD reads x5 → issue_ready_o=1, byp_sel_a_o=1; following cycle reader of x5 gets byp_sel=4; cycle after that busy clear, byp_sel=0.
- MUL x7, next instruction reads x7 → stall_core_o high 4 cycles, issues on 5th cycle with byp_sel=2.
- LD x3 then use of x3 → 1 stall cycle, then byp_sel=3. Assert mem_miss_i 3 cycles while the load is in CACHE → issue_ready_o=0 for those cycles, cnt[3] stays 1, byp_sel=3 after release.
- MUL x1 at cycle 0, ALU x2 at cycle 4 (needs slot 1 = MUL's WB) → WB-port stall 1 cycle, ALU issues cycle 5.
- MUL x4 then ALU x4 (WAW, cnt 5 ≥ 1) → stall until the MUL entry reaches cnt 0. Instruction writing x0 → never stalls, x0 never busy.
- rsn_i=1 while a MUL is in flight → next cycle all busy clear, issue_ready_o=1, byp_sel 0.
